// File: rtl/cgra_wb_cfg_bridge.sv
// Wishbone slave front-end for the CGRA: CTRL/STATUS/COUNT CSRs plus a config window bridged
// onto the CGRA valid/ready config bus. Optional macro CFG_TIMEOUT_EN bounds config waits.
module cgra_wb_cfg_bridge #(
  parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000,
  parameter int          CFG_ADDR_W         = 14,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  cfg_valid_o,
  input  logic                  cfg_ready_i,
  output logic                  cfg_we_o,
  output logic [CFG_ADDR_W-1:0] cfg_addr_o,
  output logic [31:0]           cfg_wdata_o,
  output logic [3:0]            cfg_wstrb_o,
  input  logic                  cfg_rvalid_i,
  input  logic [31:0]           cfg_rdata_i,
  output logic                  cgra_stall_o,
  output logic                  cgra_srst_o,
  output logic                  irq_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_ACK,
    ST_GUARD
  } state_t;

  state_t                  state_reg, state_next;
  logic [2:0]              ctrl_reg;
  logic                    status_tmo_reg;
  logic [31:0]             count_reg;
  logic [31:0]             dat_reg;
  logic                    cfg_valid_reg;
  logic                    cfg_we_reg;
  logic [CFG_ADDR_W-1:0]   cfg_addr_reg;
  logic [31:0]             cfg_wdata_reg;
  logic [3:0]              cfg_wstrb_reg;

  logic                    access;
  logic                    is_cfg;
  logic [5:0]              csr_idx;
  logic [31:0]             csr_rdata;
  logic                    busy;
  logic                    start_cfg;
  logic                    csr_hit;
  logic                    cfg_done;
  logic                    tmo_fire;
  logic                    tmo_hit;
  logic                    unused_ok;

  assign access  = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:16] == WISHBONE_BASE_ADDR[31:16]);
  assign is_cfg  = |wbs_adr_i[15:8];
  assign csr_idx = wbs_adr_i[7:2];
  assign busy    = (state_reg != ST_IDLE);

  // Byte-offset bits and the timeout limit are not needed by the default datapath.
  assign unused_ok = ^wbs_adr_i[1:0] ^ (TIMEOUT_CYCLES == 0);

  always_comb begin
    csr_rdata = 32'h0;
    case (csr_idx)
      6'd0:    csr_rdata = {29'h0, ctrl_reg};
      6'd1:    csr_rdata = {30'h0, status_tmo_reg, busy};
      6'd2:    csr_rdata = count_reg;
      default: csr_rdata = 32'h0;
    endcase
  end

`ifdef CFG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_reg;

  // Restarted on every new wait (request issue and request acceptance).
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt_reg <= '0;
    end else if (start_cfg || (state_reg == ST_REQ && cfg_ready_i)) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_REQ || state_reg == ST_RESP) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    start_cfg  = 1'b0;
    csr_hit    = 1'b0;
    cfg_done   = 1'b0;
    tmo_fire   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (access) begin
          if (is_cfg) begin
            state_next = ST_REQ;
            start_cfg  = 1'b1;
          end else begin
            state_next = ST_ACK;
            csr_hit    = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (cfg_ready_i) begin
          if (cfg_we_reg) begin
            state_next = ST_ACK;
            cfg_done   = 1'b1;
          end else begin
            state_next = ST_RESP;
          end
        end else if (tmo_hit) begin
          state_next = ST_ACK;
          tmo_fire   = 1'b1;
        end
      end
      ST_RESP: begin
        if (cfg_rvalid_i) begin
          state_next = ST_ACK;
          cfg_done   = 1'b1;
        end else if (tmo_hit) begin
          state_next = ST_ACK;
          tmo_fire   = 1'b1;
        end
      end
      ST_ACK:   state_next = ST_GUARD;
      ST_GUARD: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Config request channel: captured on issue, held until accepted or timed out.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cfg_valid_reg <= 1'b0;
      cfg_we_reg    <= 1'b0;
      cfg_addr_reg  <= '0;
      cfg_wdata_reg <= 32'h0;
      cfg_wstrb_reg <= 4'h0;
    end else if (start_cfg) begin
      cfg_valid_reg <= 1'b1;
      cfg_we_reg    <= wbs_we_i;
      cfg_addr_reg  <= wbs_adr_i[CFG_ADDR_W+1:2];
      cfg_wdata_reg <= wbs_dat_i;
      cfg_wstrb_reg <= wbs_sel_i;
    end else if (state_reg == ST_REQ && (cfg_ready_i || tmo_fire)) begin
      cfg_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_reg       <= 3'b001;
      status_tmo_reg <= 1'b0;
      count_reg      <= 32'h0;
      dat_reg        <= 32'h0;
    end else begin
      if (csr_hit) begin
        dat_reg <= wbs_we_i ? 32'h0 : csr_rdata;
        if (wbs_we_i && wbs_sel_i[0]) begin
          if (csr_idx == 6'd0) begin
            ctrl_reg <= wbs_dat_i[2:0];
          end
          if (csr_idx == 6'd1 && wbs_dat_i[1]) begin
            status_tmo_reg <= 1'b0;
          end
        end
      end
      if (cfg_done) begin
        count_reg <= count_reg + 32'd1;
        dat_reg   <= (state_reg == ST_RESP) ? cfg_rdata_i : 32'h0;
      end
      // Placed last so a timeout set takes priority over any clear.
      if (tmo_fire) begin
        status_tmo_reg <= 1'b1;
        dat_reg        <= 32'hDEAD_BEEF;
      end
    end
  end

  assign wbs_ack_o    = (state_reg == ST_ACK);
  assign wbs_dat_o    = dat_reg;
  assign cfg_valid_o  = cfg_valid_reg;
  assign cfg_we_o     = cfg_we_reg;
  assign cfg_addr_o   = cfg_addr_reg;
  assign cfg_wdata_o  = cfg_wdata_reg;
  assign cfg_wstrb_o  = cfg_wstrb_reg;
  assign cgra_stall_o = ctrl_reg[0];
  assign cgra_srst_o  = ctrl_reg[1];
  assign irq_o        = status_tmo_reg & ctrl_reg[2];

endmodule

// File: tb/tb_cgra_wb_cfg_bridge.sv
// Self-checking bench for cgra_wb_cfg_bridge: random Wishbone traffic against a CSR/counter model
// and a behavioural config-bus responder. Timeout scenario runs only with CFG_TIMEOUT_EN.
module tb_cgra_wb_cfg_bridge;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TMO  = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat_w = 32'h0;
  logic        ack;
  logic [31:0] dat_r;
  logic        cfg_valid, cfg_we;
  logic        cfg_ready = 1'b0, cfg_rvalid = 1'b0;
  logic [13:0] cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata = 32'h0;
  logic [3:0]  cfg_wstrb;
  logic        stall, srst_o, irq;

  int checks = 0;
  int failures = 0;

  // Behavioural model of architectural state
  logic [2:0]  ctrl_m;
  logic        tmo_m;
  logic [31:0] count_m;

  // Results of the most recent bus access
  bit          r_acked, r_saw_req, r_stable;
  int          r_lat;
  logic [31:0] r_rd, r_wdata;
  logic        r_ack_next, r_we, r_valid_after;
  logic [13:0] r_addr;
  logic [3:0]  r_wstrb;

  always #5 clk = ~clk;

  cgra_wb_cfg_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .cfg_valid_o(cfg_valid), .cfg_ready_i(cfg_ready), .cfg_we_o(cfg_we),
    .cfg_addr_o(cfg_addr), .cfg_wdata_o(cfg_wdata), .cfg_wstrb_o(cfg_wstrb),
    .cfg_rvalid_i(cfg_rvalid), .cfg_rdata_i(cfg_rdata),
    .cgra_stall_o(stall), .cgra_srst_o(srst_o), .irq_o(irq)
  );

  function automatic logic [31:0] exp_csr(input logic [31:0] a);
    case (a[7:2])
      6'd0:    return {29'h0, ctrl_m};
      6'd1:    return {30'h0, tmo_m, 1'b0};
      6'd2:    return count_m;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_csr_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (s[0] && a[7:2] == 6'd0) ctrl_m = d[2:0];
    if (s[0] && a[7:2] == 6'd1 && d[1]) tmo_m = 1'b0;
  endtask

  // One Wishbone access with a config-bus responder: ready after rdy_dly cycles of valid
  // (0 = never), rvalid rv_dly cycles after acceptance for reads.
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int rdy_dly, input int rv_dly,
                           input logic [31:0] rdata, input int budget);
    int  waited, rv_cnt;
    bit  accepted, rv_done;
    r_acked = 0; r_saw_req = 0; r_stable = 1; r_lat = 0; r_rd = 32'h0; r_ack_next = 1'b0;
    r_valid_after = 1'b1; waited = 0; rv_cnt = 0; accepted = 0; rv_done = 0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (cfg_rvalid) cfg_rvalid = 1'b0;
      if (cfg_ready) begin
        cfg_ready = 1'b0; accepted = 1; r_valid_after = cfg_valid;
      end
      if (ack) begin
        r_acked = 1; r_lat = n; r_rd = dat_r;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        r_ack_next = ack;
        break;
      end
      if (cfg_valid && !accepted) begin
        if (!r_saw_req) begin
          r_saw_req = 1; r_addr = cfg_addr; r_we = cfg_we; r_wdata = cfg_wdata; r_wstrb = cfg_wstrb;
        end else if (cfg_addr !== r_addr || cfg_we !== r_we || cfg_wdata !== r_wdata ||
                     cfg_wstrb !== r_wstrb) begin
          r_stable = 0;
        end
        if (waited == rdy_dly - 1) cfg_ready = 1'b1;
        waited++;
      end else if (accepted && !r_we && !rv_done) begin
        if (rv_cnt == rv_dly - 1) begin
          cfg_rvalid = 1'b1; cfg_rdata = rdata; rv_done = 1;
        end
        rv_cnt++;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; cfg_ready = 1'b0; cfg_rvalid = 1'b0;
    $display("txn we=%0b adr=%h wdat=%h sel=%h acked=%0b lat=%0d rdat=%h", w, a, d, s, r_acked, r_lat, r_rd);
  endtask

  task automatic csr_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input string name);
    logic [31:0] exp;
    exp = exp_csr(a);
    wb_access(w, a, d, s, 1, 1, 32'h0, 50);
    if (w) model_csr_write(a, d, s);
    checks++; if (r_acked !== 1'b1 || r_lat != 1) begin failures++; $display("FAIL %s_lat got=%0d/%0b exp=1/1", name, r_lat, r_acked); end
    checks++; if (r_ack_next !== 1'b0) begin failures++; $display("FAIL %s_ack_pulse got=%b exp=0", name, r_ack_next); end
    if (!w) begin
      checks++; if (r_rd !== exp) begin failures++; $display("FAIL %s_rdata got=%h exp=%h", name, r_rd, exp); end
    end
  endtask

  task automatic check_pins(input string name);
    checks++;
    if ({stall, srst_o, irq} !== {ctrl_m[0], ctrl_m[1], tmo_m & ctrl_m[2]}) begin
      failures++;
      $display("FAIL %s_pins got=%b exp=%b", name, {stall, srst_o, irq}, {ctrl_m[0], ctrl_m[1], tmo_m & ctrl_m[2]});
    end
  endtask

  task automatic cfg_op(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int rn, input int rv, input string name);
    logic [31:0] rdata;
    int exp_lat;
    rdata = $urandom;
    exp_lat = w ? 1 + rn : 1 + rn + rv;
    wb_access(w, a, d, s, rn, rv, rdata, 400);
    count_m++;
    checks++; if (r_acked !== 1'b1 || r_lat != exp_lat) begin failures++; $display("FAIL %s_lat got=%0d/%0b exp=%0d/1", name, r_lat, r_acked, exp_lat); end
    checks++; if (r_saw_req !== 1'b1 || r_addr !== a[15:2] || r_we !== w || r_wstrb !== s) begin
      failures++; $display("FAIL %s_req got=%0b/%h/%b/%h exp=1/%h/%b/%h", name, r_saw_req, r_addr, r_we, r_wstrb, a[15:2], w, s); end
    if (w) begin
      checks++; if (r_wdata !== d) begin failures++; $display("FAIL %s_wdata got=%h exp=%h", name, r_wdata, d); end
    end else begin
      checks++; if (r_rd !== rdata) begin failures++; $display("FAIL %s_rdata got=%h exp=%h", name, r_rd, rdata); end
    end
    checks++; if (r_valid_after !== 1'b0 || r_stable !== 1 || r_ack_next !== 1'b0) begin
      failures++; $display("FAIL %s_handshake got=%b/%0b/%b exp=0/1/0", name, r_valid_after, r_stable, r_ack_next); end
  endtask

  function automatic logic [31:0] rand_cfg_adr();
    logic [31:0] off;
    off = $urandom_range(32'h40, 32'h3FFF);
    return BASE | (off << 2);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    ctrl_m = 3'b001; tmo_m = 1'b0; count_m = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ack !== 1'b0 || dat_r !== 32'h0 || cfg_valid !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got=%b/%h/%b exp=0/0/0", ack, dat_r, cfg_valid); end
    check_pins("reset");
    csr_access(1'b0, BASE, 32'h0, 4'hF, "reset_ctrl");
    csr_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, "reset_status");
    csr_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, "reset_count");
  endtask

  task automatic test_cfg_write();
    cfg_op(1'b1, BASE + 32'h100, 32'hA5A5_0001, 4'hF, 3, 1, "cfg_wr_dir");
    for (int i = 0; i < 6; i++)
      cfg_op(1'b1, rand_cfg_adr(), $urandom, 4'($urandom_range(1, 15)), $urandom_range(1, 5), 1, "cfg_wr_rnd");
    csr_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, "cfg_wr_count");
  endtask

  task automatic test_cfg_read();
    logic [31:0] rdata;
    rdata = 32'h1234_5678;
    wb_access(1'b0, BASE + 32'h104, 32'h0, 4'hF, 1, 2, rdata, 400);
    count_m++;
    checks++; if (r_rd !== 32'h1234_5678 || r_lat != 4 || r_addr !== 14'h41) begin
      failures++; $display("FAIL cfg_rd_dir got=%h/%0d/%h exp=12345678/4/0041", r_rd, r_lat, r_addr); end
    for (int i = 0; i < 6; i++)
      cfg_op(1'b0, rand_cfg_adr(), 32'h0, 4'($urandom_range(1, 15)), $urandom_range(1, 4), $urandom_range(1, 4), "cfg_rd_rnd");
    csr_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, "cfg_rd_count");
  endtask

  task automatic test_csr();
    csr_access(1'b1, BASE, 32'h0000_0006, 4'h1, "ctrl_wr");
    csr_access(1'b0, BASE, 32'h0, 4'hF, "ctrl_rd6");
    check_pins("ctrl6");
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      a = BASE | (32'($urandom_range(0, 63)) << 2);
      csr_access(1'b1, a, $urandom, 4'($urandom_range(0, 15)), "csr_wr_rnd");
      csr_access(1'b0, a, 32'h0, 4'hF, "csr_rd_rnd");
      check_pins("csr_rnd");
    end
    csr_access(1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, "count_ro_wr");
    csr_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, "count_ro_rd");
  endtask

  task automatic test_window_miss();
    wb_access(1'b0, 32'h3001_0000, 32'h0, 4'hF, 1, 1, 32'h0, 20);
    checks++; if (r_acked !== 0 || r_saw_req !== 0) begin
      failures++; $display("FAIL window_miss got=%0b/%0b exp=0/0", r_acked, r_saw_req); end
    wb_access(1'b1, 32'h2000_0100, 32'h5, 4'hF, 1, 1, 32'h0, 20);
    checks++; if (r_acked !== 0 || r_saw_req !== 0) begin
      failures++; $display("FAIL window_miss_cfg got=%0b/%0b exp=0/0", r_acked, r_saw_req); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: cfg_op(1'b1, rand_cfg_adr(), $urandom, 4'hF, $urandom_range(1, 3), 1, "b2b_wr");
        1: cfg_op(1'b0, rand_cfg_adr(), 32'h0, 4'hF, $urandom_range(1, 3), $urandom_range(1, 3), "b2b_rd");
        2: csr_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, "b2b_count");
        default: csr_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, "b2b_status");
      endcase
    end
  endtask

`ifdef CFG_TIMEOUT_EN
  task automatic test_timeout();
    wb_access(1'b1, BASE + 32'h200, 32'h1, 4'hF, 0, 1, 32'h0, 400);
    tmo_m = 1'b1;
    checks++; if (r_acked !== 1 || r_lat != 1 + TMO || r_rd !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL timeout_ack got=%0b/%0d/%h exp=1/%0d/deadbeef", r_acked, r_lat, r_rd, 1 + TMO); end
    csr_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, "timeout_status");
    csr_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, "timeout_count");
    csr_access(1'b1, BASE, 32'h4, 4'hF, "timeout_irqen");
    check_pins("timeout_irq");
    csr_access(1'b1, BASE + 32'h4, 32'h2, 4'h1, "timeout_w1c");
    csr_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, "timeout_status_clr");
    check_pins("timeout_irq_clr");
  endtask
`endif

  task automatic test_reset_mid();
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h300; dat_w = 32'h77; sel = 4'hF;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (cfg_valid !== 1'b1) begin failures++; $display("FAIL midrst_req got=%b exp=1", cfg_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    ctrl_m = 3'b001; tmo_m = 1'b0; count_m = 32'h0;
    checks++; if (cfg_valid !== 1'b0 || ack !== 1'b0) begin
      failures++; $display("FAIL midrst_out got=%b/%b exp=0/0", cfg_valid, ack); end
    check_pins("midrst");
    rst = 1'b0;
    csr_access(1'b0, BASE, 32'h0, 4'hF, "midrst_ctrl");
    csr_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, "midrst_count");
  endtask

  initial begin
    test_reset();
    test_cfg_write();
    test_cfg_read();
    test_csr();
    test_window_miss();
    test_back_to_back();
`ifdef CFG_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
